spi_fsm_controller: RTL and testbench
=====================================

// Module: spi_fsm_controller
// PURPOSE
//   Sequencing FSM for the SPI memory peripheral. Counts conditioned SCLK edges while CS is
//   low, then drives the control strobes for the 8-bit shift register (parallelLoad),
//   address latch, data memory write enable and MISO tri-state buffer.
//   Sits between the input conditioners and the shiftregister/datamemory datapath.
// PARAMETERS
//   WIDTH      8  bits per SPI byte (address+R/W byte and data byte); >= 2
//   CNT_WIDTH  4  bit-counter width; must satisfy 2**CNT_WIDTH > WIDTH
// PORTS
//   clk                input   1  system clock; all state updates on posedge
//   resetN             input   1  synchronous reset, active low
//   csConditioned      input   1  chip select, active low, already synchronized
//   sclkPosEdge        input   1  one-clk pulse per SCLK rise (also the shift register's peripheralClkEdge)
//   sclkNegEdge        input   1  one-clk pulse per SCLK fall
//   rwBit              input   1  shift register parallelDataOut[0]; 1 = read, 0 = write
//   addrWe             output  1  latch parallelDataOut[WIDTH-1:1] into the address register
//   srWe               output  1  parallelLoad to the shift register (load memory read data)
//   dmWe               output  1  data memory write enable
//   misoBufe           output  1  MISO tri-state buffer enable
//   busy               output  1  high in every state except IDLE
// BEHAVIOUR
// - Reset: synchronous, active low; resetN==0 at a posedge -> state IDLE, counter 0; beats all other inputs.
//   Reset asserted mid-transaction aborts it the same edge; every output reads 0 the cycle after.
// - All outputs are Moore (decoded from state only); none are combinational on inputs.
// - States and transitions (evaluated each posedge clk):
//   IDLE      : csConditioned==0 -> GET_ADDR (counter cleared)
//   GET_ADDR  : counter +1 on each sclkPosEdge; the pulse that brings counter to WIDTH -> GOT_ADDR
//   GOT_ADDR  : addrWe=1 for exactly 1 clk; rwBit sampled this cycle; 1 -> READ_WAIT, 0 -> WRITE_GET
//   READ_WAIT : 1 clk bubble for memory read data to settle; -> READ_LOAD
//   READ_LOAD : srWe=1 for exactly 1 clk; counter cleared; -> READ_SHIFT
//   READ_SHIFT: misoBufe=1; counter +1 per sclkNegEdge; the pulse reaching WIDTH -> DONE
//   WRITE_GET : counter +1 per sclkPosEdge; the pulse reaching WIDTH -> WRITE_STORE
//   WRITE_STORE: dmWe=1 for exactly 1 clk; -> DONE
//   DONE      : all strobes 0; wait for csConditioned==1
// - csConditioned==1 in any non-IDLE state -> IDLE next clk, counter cleared; priority over
//   every other transition (an aborted write never reaches WRITE_STORE, so no dmWe).
// - Edge pulses not relevant to the current state are ignored (negEdge in GET_ADDR/WRITE_GET,
//   posEdge in READ_SHIFT, both in GOT_ADDR/READ_WAIT/READ_LOAD/WRITE_STORE/DONE).
// - Counter increments only in counting states; counter == WIDTH never persists (the state
//   changes the same edge); no wrap-around is possible.
// - busy = (state != IDLE). Latency: addrWe exactly 1 clk after the WIDTH-th address posedge;
//   srWe 3 clks after it; dmWe 1 clk after the WIDTH-th data posedge.
// - Back-to-back transactions need CS high for >= 1 clk (DONE->IDLE->GET_ADDR).
// TESTING
//   1 reset: resetN=0 for 2 clks with CS low and edge pulses toggling -> all outputs 0, busy=0.
//   2 write: CS low, 8 posEdge pulses with rwBit=0 at GOT_ADDR, then 8 more posEdge pulses ->
//     addrWe one 1-clk pulse, dmWe one 1-clk pulse exactly 1 clk after 16th posEdge; srWe and misoBufe stay 0.
//   3 read: CS low, 8 posEdge pulses, rwBit=1 -> addrWe pulse, srWe pulse 3 clks after 8th posEdge;
//     misoBufe high from the next clk through the 8th negEdge, low 1 clk later; dmWe stays 0.
//   4 abort: CS high after 5 data posEdge pulses of a write -> IDLE next clk, no dmWe;
//     next CS-low transaction addresses correctly (counter restarted at 0).
//   5 ignored edges: negEdge pulses during GET_ADDR and posEdge pulses during READ_SHIFT -> counts unchanged,
//     strobe timing identical to scenarios 2/3.
//   6 reset mid-read: resetN=0 while misoBufe=1 -> misoBufe=0 and busy=0 the clk after the sampling edge.

Source files
------------

// File: rtl/spi_fsm_if.sv
// Handshake bundle between the SPI input conditioners/shift register and the
// sequencing FSM: conditioned SPI events in, datapath control strobes out.
interface spi_fsm_if;
  logic csConditioned;
  logic sclkPosEdge;
  logic sclkNegEdge;
  logic rwBit;
  logic addrWe;
  logic srWe;
  logic dmWe;
  logic misoBufe;
  logic busy;

  modport master (
    output csConditioned,
    output sclkPosEdge,
    output sclkNegEdge,
    output rwBit,
    input  addrWe,
    input  srWe,
    input  dmWe,
    input  misoBufe,
    input  busy
  );

  modport slave (
    input  csConditioned,
    input  sclkPosEdge,
    input  sclkNegEdge,
    input  rwBit,
    output addrWe,
    output srWe,
    output dmWe,
    output misoBufe,
    output busy
  );
endinterface

// File: rtl/spi_fsm_controller.sv
// SPI memory peripheral sequencer: counts conditioned SCLK edges while CS is low
// and issues address-latch, parallel-load, memory-write and MISO-enable strobes.
module spi_fsm_controller #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic     clk,
  input  logic     resetN,
  spi_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GOT_ADDR,
    READ_WAIT,
    READ_LOAD,
    READ_SHIFT,
    WRITE_GET,
    WRITE_STORE,
    DONE
  } state_t;

  // The counter is cleared on the pulse that would reach WIDTH, so it never holds WIDTH.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 addr_we_q, addr_we_d;
  logic                 sr_we_q, sr_we_d;
  logic                 dm_we_q, dm_we_d;
  logic                 miso_bufe_q, miso_bufe_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q != IDLE && bus.csConditioned) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!bus.csConditioned) begin
            state_d = GET_ADDR;
          end
        end
        GET_ADDR: begin
          if (bus.sclkPosEdge) begin
            if (cnt_q == LAST_CNT) begin
              state_d = GOT_ADDR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        GOT_ADDR: begin
          cnt_d   = '0;
          state_d = bus.rwBit ? READ_WAIT : WRITE_GET;
        end
        READ_WAIT: begin
          state_d = READ_LOAD;
        end
        READ_LOAD: begin
          cnt_d   = '0;
          state_d = READ_SHIFT;
        end
        READ_SHIFT: begin
          if (bus.sclkNegEdge) begin
            if (cnt_q == LAST_CNT) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        WRITE_GET: begin
          if (bus.sclkPosEdge) begin
            if (cnt_q == LAST_CNT) begin
              state_d = WRITE_STORE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        WRITE_STORE: begin
          state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Strobes are decoded from the next state and registered, so they are
  // glitch-free Moore outputs aligned with the state they belong to.
  always_comb begin
    addr_we_d   = (state_d == GOT_ADDR);
    sr_we_d     = (state_d == READ_LOAD);
    dm_we_d     = (state_d == WRITE_STORE);
    miso_bufe_d = (state_d == READ_SHIFT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_we_q   <= 1'b0;
      sr_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      miso_bufe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_we_q   <= addr_we_d;
      sr_we_q     <= sr_we_d;
      dm_we_q     <= dm_we_d;
      miso_bufe_q <= miso_bufe_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.addrWe   = addr_we_q;
  assign bus.srWe     = sr_we_q;
  assign bus.dmWe     = dm_we_q;
  assign bus.misoBufe = miso_bufe_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_fsm_controller.sv
// Randomized directed bench for spi_fsm_controller: stimulus is recorded per cycle and
// expected strobe timelines are derived from pulse positions in that record.
module tb_spi_fsm_controller;
  localparam int W    = 8;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  spi_fsm_if bus ();

  spi_fsm_controller #(.WIDTH(W), .CNT_WIDTH(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  // Per-cycle record: inputs sampled at edge c, outputs observed just after edge c.
  // Output vector bits: {busy, addrWe, srWe, dmWe, misoBufe}.
  logic       s_rst [MAXC];
  logic       s_cs  [MAXC];
  logic       s_pos [MAXC];
  logic       s_neg [MAXC];
  logic       s_rw  [MAXC];
  logic [4:0] obs   [MAXC];
  logic [4:0] expv  [MAXC];

  int cyc      = 0;
  int checked  = 0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int c, input logic [4:0] observed, input logic [4:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, observed, expected);
    end
  endtask

  task automatic step(input logic rst, input logic cs, input logic pos, input logic neg, input logic rw);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d required<%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    resetN            = rst;
    bus.csConditioned = cs;
    bus.sclkPosEdge   = pos;
    bus.sclkNegEdge   = neg;
    bus.rwBit         = rw;
    s_rst[cyc] = rst;
    s_cs[cyc]  = cs;
    s_pos[cyc] = pos;
    s_neg[cyc] = neg;
    s_rw[cyc]  = rw;
    @(posedge clk);
    #1;
    obs[cyc] = {bus.busy, bus.addrWe, bus.srWe, bus.dmWe, bus.misoBufe};
    cyc++;
  endtask

  // Cycle of the n-th pulse of the given kind in [from, lim); lim if it never arrives.
  function automatic int nth(input int from, input int n, input bit neg_kind, input int lim);
    int k = 0;
    for (int c = from; c < lim; c++) begin
      if ((neg_kind ? s_neg[c] : s_pos[c]) === 1'b1) begin
        k++;
        if (k == n) return c;
      end
    end
    return lim;
  endfunction

  // A transaction opens at the first cycle with CS low while idle and ends at the first
  // cycle where CS is high or reset is low; strobe positions follow from pulse counts.
  task automatic build_model();
    int c, a, ab, p8, d8, n8;
    for (int k = 0; k < cyc; k++) expv[k] = 5'b0;
    c = 0;
    while (c < cyc) begin
      if (s_rst[c] === 1'b1 && s_cs[c] === 1'b0) begin
        a  = c;
        ab = a + 1;
        while (ab < cyc && s_rst[ab] === 1'b1 && s_cs[ab] === 1'b0) ab++;
        for (int k = a; k < ab; k++) expv[k][4] = 1'b1;
        p8 = nth(a + 1, W, 1'b0, ab);
        if (p8 < ab) begin
          expv[p8][3] = 1'b1;
          if (p8 + 1 < ab) begin
            if (s_rw[p8 + 1] === 1'b1) begin
              if (p8 + 2 < ab) expv[p8 + 2][2] = 1'b1;
              n8 = nth(p8 + 4, W, 1'b1, ab);
              for (int k = p8 + 3; k < n8; k++) expv[k][0] = 1'b1;
            end else begin
              d8 = nth(p8 + 2, W, 1'b0, ab);
              if (d8 < ab) expv[d8][1] = 1'b1;
            end
          end
        end
        c = ab + 1;
      end else begin
        c++;
      end
    end
  endtask

  task automatic check_upto(input string tag);
    build_model();
    for (int c = checked; c < cyc; c++) chk(tag, c, obs[c], expv[c]);
    checked = cyc;
  endtask

  // One CS-low frame: W address posEdges, then data_pulses data edges, then CS high.
  task automatic txn(input logic rw, input int data_pulses, input bit noise);
    int ng;
    logic nz;
    step(1'b1, 1'b0, 1'b0, 1'b0, rw);
    for (int i = 0; i < W; i++) begin
      ng = int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
        nz = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        step(1'b1, 1'b0, 1'b0, nz, rw);
      end
      step(1'b1, 1'b0, 1'b1, 1'b0, rw);
    end
    if (rw) begin
      ng = 3 + int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) step(1'b1, 1'b0, 1'b0, 1'b0, rw);
      for (int i = 0; i < data_pulses; i++) begin
        ng = int'($urandom_range(0, 2));
        for (int g = 0; g < ng; g++) begin
          nz = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          step(1'b1, 1'b0, nz, 1'b0, rw);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, rw);
      end
    end else begin
      for (int i = 0; i < data_pulses; i++) begin
        ng = int'($urandom_range(0, 2));
        for (int g = 0; g < ng; g++) begin
          nz = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          step(1'b1, 1'b0, 1'b0, nz, rw);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, rw);
      end
    end
    if (data_pulses >= W) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, rw);
      step(1'b1, 1'b0, 1'b0, 1'b0, rw);
    end
    ng = 1 + int'($urandom_range(0, 1));
    for (int g = 0; g < ng; g++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetN            = 1'b0;
    bus.csConditioned = 1'b1;
    bus.sclkPosEdge   = 1'b0;
    bus.sclkNegEdge   = 1'b0;
    bus.rwBit         = 1'b0;

    // Reset held with CS low and edge pulses toggling.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset_outputs", cyc - 1, obs[cyc - 1], 5'b00000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_upto("reset");

    repeat (3) txn(1'b0, W, 1'b0);
    check_upto("write");

    repeat (3) txn(1'b1, W, 1'b0);
    check_upto("read");

    txn(1'b0, 5, 1'b0);
    txn(1'b0, W, 1'b0);
    check_upto("abort");

    repeat (2) begin
      txn(1'b0, W, 1'b1);
      txn(1'b1, W, 1'b1);
    end
    check_upto("ignored_edges");

    // Reset pulse while MISO is being driven.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    chk("miso_before_reset", cyc - 1, obs[cyc - 1], 5'b10001);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("miso_after_reset", cyc - 1, obs[cyc - 1], 5'b00000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_upto("reset_mid_read");

    repeat (12) begin
      txn(1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : W,
          1'($urandom_range(0, 1)));
    end
    check_upto("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
